rnn_seq_core: RTL and testbench

Parametrised fixed-point Elman RNN engine. It runs HID hidden neurons over T timesteps of an IN_BITS-wide binary input vector. All weights and biases are fetched through the shared single-port memory interface, and every h_t[j] is written back to the output region. This engine sits between the host input stream (idata/i_en) and the weight/result SRAM, and generalises the fixed 64×32 core to arbitrary size with selectable activation.

---
 rtl/rnn_pkg.sv | 48 ++++
 rtl/rnn_mac_sat.sv | 84 ++++++++
 rtl/rnn_seq_core.sv | 224 ++++++++++++++++++++++
 tb/tb_rnn_seq_core.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rnn_pkg.sv
// Shared definitions for the Elman RNN sequencer.
// Holds the memory region codes, the activation select encoding, the
// sequencer state enum, the accumulator add mode and fixed-point helpers.
package rnn_pkg;

    // Memory regions selected by msel
    localparam logic [2:0] MSEL_WX  = 3'b000;
    localparam logic [2:0] MSEL_B1  = 3'b001;
    localparam logic [2:0] MSEL_WH  = 3'b010;
    localparam logic [2:0] MSEL_B2  = 3'b011;
    localparam logic [2:0] MSEL_HDR = 3'b100;
    localparam logic [2:0] MSEL_OUT = 3'b101;

    // Activation select
    localparam logic ACT_TANH = 1'b0;
    localparam logic ACT_RELU = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HWAIT,
        S_INREQ,
        S_INCAP,
        S_READ,
        S_DRAIN,
        S_WRITE
    } state_t;

    // MAC_ADD: gated value << FRAC; MAC_MUL: full DWxDW product
    typedef enum logic {
        MAC_ADD,
        MAC_MUL
    } mac_mode_t;

    // Fixed-point helpers: 1.0 and the DW-bit signed extremes
    function automatic longint fx_one(input int frac);
        return longint'(1) <<< frac;
    endfunction

    function automatic longint fx_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint fx_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/rnn_mac_sat.sv
// Multiply-accumulate with rounding and activation saturation.
// Ports: clk/reset; clr zeroes the accumulator; en adds the selected term
// (MAC_ADD: din sign-extended << FRAC when gate=1; MAC_MUL: din*hin).
// result is the accumulator rounded half away from zero to FRAC fraction
// bits and clamped by act_sel (hard-tanh +/-1.0 or ReLU up to DW max).
module rnn_mac_sat
    import rnn_pkg::*;
#(
    parameter int DW   = 20,
    parameter int FRAC = 16,
    parameter int ACCW = 46
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  mac_mode_t            mode,
    input  logic                 gate,
    input  logic signed [DW-1:0] din,
    input  logic signed [DW-1:0] hin,
    input  logic                 act_sel,
    output logic signed [DW-1:0] result
);

    localparam int RW = ACCW + 1;
    localparam logic signed [RW-1:0] POS_ONE = RW'(fx_one(FRAC));
    localparam logic signed [RW-1:0] NEG_ONE = -POS_ONE;
    localparam logic signed [RW-1:0] D_MAX   = RW'(fx_max(DW));
    localparam logic [RW-1:0]        HALF    = RW'(1) << (FRAC - 1);

    logic signed [ACCW-1:0] acc_reg;
    logic signed [ACCW-1:0] term;
    logic signed [2*DW-1:0] prod;
    logic signed [RW-1:0]   acc_ext;
    logic [RW-1:0]          mag;
    logic [RW-1:0]          qmag;
    logic signed [RW-1:0]   rnd;
    logic                   neg;

    always_comb begin
        prod = din * hin;
        term = '0;
        if (mode == MAC_MUL) begin
            term = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
        end else if (gate) begin
            term = {{(ACCW-DW){din[DW-1]}}, din} <<< FRAC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + term;
        end
    end

    // Round on the magnitude so halves move away from zero for both signs
    always_comb begin
        acc_ext = {acc_reg[ACCW-1], acc_reg};
        neg     = acc_reg[ACCW-1];
        mag     = neg ? RW'(-acc_ext) : RW'(acc_ext);
        qmag    = (mag + HALF) >> FRAC;
        rnd     = neg ? -$signed(qmag) : $signed(qmag);
    end

    always_comb begin
        result = rnd[DW-1:0];
        if (act_sel == ACT_RELU) begin
            if (rnd < 0) begin
                result = '0;
            end else if (rnd > D_MAX) begin
                result = D_MAX[DW-1:0];
            end
        end else begin
            if (rnd > POS_ONE) begin
                result = POS_ONE[DW-1:0];
            end else if (rnd < NEG_ONE) begin
                result = NEG_ONE[DW-1:0];
            end
        end
    end

endmodule

// File: rtl/rnn_seq_core.sv
// Fixed-point Elman RNN sequencer: HID neurons over T timesteps.
// Ports: clk/reset (sync, active-high); ready starts a run from idle;
// act_sel picks the activation (sampled at start); idata is x_t, captured
// one cycle after the i_en pulse; mce/msel/maddr address the weight/result
// memory, mdata_r returns read data one cycle later, mdata_w carries h_t[j]
// on output writes; busy is high for the whole run.
module rnn_seq_core
    import rnn_pkg::*;
#(
    parameter int HID     = 64,
    parameter int IN_BITS = 32,
    parameter int DW      = 20,
    parameter int FRAC    = 16,
    parameter int TW      = 11,
    parameter int AW      = 17,
    parameter int ACCW    = 2*DW + $clog2(IN_BITS + HID + 2)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    input  logic          act_sel,
    input  logic [31:0]   idata,
    input  logic [DW-1:0] mdata_r,
    output logic          busy,
    output logic          i_en,
    output logic          mce,
    output logic [2:0]    msel,
    output logic [AW-1:0] maddr,
    output logic [DW-1:0] mdata_w
);

    localparam int JW = $clog2(HID);
    localparam int KW = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
    localparam int CW = $clog2(IN_BITS + HID + 3);

    state_t               state_reg, state_next;
    logic [TW-1:0]        t_reg, t_next, t_len_reg, t_len_next;
    logic [JW-1:0]        j_reg, j_next;
    logic [CW-1:0]        cnt_reg, cnt_next, r_last;
    logic [IN_BITS-1:0]   x_reg, x_next;
    logic                 act_reg, act_next;
    logic                 bank_sel_reg, bank_sel_next;
    logic                 dat_vld_reg;
    logic [CW-1:0]        dat_idx_reg;

    logic                 mac_clr, mac_gate;
    mac_mode_t            mac_mode;
    logic signed [DW-1:0] mac_hin, mac_result;
    logic [KW-1:0]        k_idx;
    logic [JW-1:0]        hi_idx;
    logic signed [DW-1:0] h_old [HID];
    logic                 unused_idata;

    assign unused_idata = ^idata;
    assign busy         = (state_reg != S_IDLE);
    // Index of the last read request of the neuron (Wh phase only for t>0)
    assign r_last       = (t_reg == '0) ? CW'(IN_BITS + 1) : CW'(IN_BITS + HID + 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            t_reg        <= '0;
            t_len_reg    <= '0;
            j_reg        <= '0;
            cnt_reg      <= '0;
            x_reg        <= '0;
            act_reg      <= ACT_TANH;
            bank_sel_reg <= 1'b0;
            dat_vld_reg  <= 1'b0;
            dat_idx_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            t_reg        <= t_next;
            t_len_reg    <= t_len_next;
            j_reg        <= j_next;
            cnt_reg      <= cnt_next;
            x_reg        <= x_next;
            act_reg      <= act_next;
            bank_sel_reg <= bank_sel_next;
            // Read data lags its request by one cycle; remember what was asked
            dat_vld_reg  <= (state_reg == S_READ);
            dat_idx_reg  <= cnt_reg;
        end
    end

    always_comb begin
        state_next    = state_reg;
        t_next        = t_reg;
        t_len_next    = t_len_reg;
        j_next        = j_reg;
        cnt_next      = cnt_reg;
        x_next        = x_reg;
        act_next      = act_reg;
        bank_sel_next = bank_sel_reg;
        i_en          = 1'b0;
        mce           = 1'b0;
        msel          = MSEL_HDR;
        maddr         = '0;
        mdata_w       = '0;
        mac_clr       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (ready) begin
                    state_next = S_HDR;
                    act_next   = act_sel;
                end
            end
            S_HDR: begin
                mce        = 1'b1;
                state_next = S_HWAIT;
            end
            S_HWAIT: begin
                t_len_next = mdata_r[TW-1:0];
                state_next = (mdata_r[TW-1:0] == '0) ? S_IDLE : S_INREQ;
            end
            S_INREQ: begin
                i_en       = 1'b1;
                state_next = S_INCAP;
            end
            S_INCAP: begin
                x_next     = idata[IN_BITS-1:0];
                cnt_next   = '0;
                state_next = S_READ;
            end
            S_READ: begin
                mce      = 1'b1;
                mac_clr  = (cnt_reg == '0);
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == '0) begin
                    msel  = MSEL_B1;
                    maddr = AW'(j_reg);
                end else if (cnt_reg == CW'(1)) begin
                    msel  = MSEL_B2;
                    maddr = AW'(j_reg);
                end else if (cnt_reg <= CW'(IN_BITS + 1)) begin
                    msel  = MSEL_WX;
                    maddr = AW'(j_reg) * AW'(IN_BITS) + AW'(cnt_reg - CW'(2));
                end else begin
                    msel  = MSEL_WH;
                    maddr = AW'(j_reg) * AW'(HID) + AW'(cnt_reg - CW'(IN_BITS + 2));
                end
                if (cnt_reg == r_last) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_next = S_WRITE;
            end
            S_WRITE: begin
                mce     = 1'b1;
                msel    = MSEL_OUT;
                maddr   = AW'(t_reg) * AW'(HID) + AW'(j_reg);
                mdata_w = mac_result;
                if (j_reg != JW'(HID - 1)) begin
                    j_next     = j_reg + JW'(1);
                    cnt_next   = '0;
                    state_next = S_READ;
                end else if (t_reg != t_len_reg - TW'(1)) begin
                    bank_sel_next = ~bank_sel_reg;
                    t_next        = t_reg + TW'(1);
                    j_next        = '0;
                    state_next    = S_INREQ;
                end else begin
                    t_next     = '0;
                    j_next     = '0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Classify the datum arriving this cycle by its request index
    always_comb begin
        k_idx    = KW'(dat_idx_reg - CW'(2));
        hi_idx   = JW'(dat_idx_reg - CW'(IN_BITS + 2));
        mac_mode = MAC_ADD;
        mac_gate = 1'b1;
        mac_hin  = h_old[hi_idx];
        if (dat_idx_reg >= CW'(IN_BITS + 2)) begin
            mac_mode = MAC_MUL;
        end else if (dat_idx_reg >= CW'(2)) begin
            mac_gate = x_reg[k_idx];
        end
    end

    // Two hidden-state banks; bank_sel_reg=0 means A is old, B is new.
    // Banks are never cleared: t=0 skips the Wh phase instead.
    genvar gi;
    generate
        for (gi = 0; gi < HID; gi++) begin : g_hid
            logic signed [DW-1:0] bank_a_reg;
            logic signed [DW-1:0] bank_b_reg;
            always_ff @(posedge clk) begin
                if (!reset && state_reg == S_WRITE && j_reg == JW'(gi)) begin
                    if (bank_sel_reg) begin
                        bank_a_reg <= mac_result;
                    end else begin
                        bank_b_reg <= mac_result;
                    end
                end
            end
            assign h_old[gi] = bank_sel_reg ? bank_b_reg : bank_a_reg;
        end
    endgenerate

    rnn_mac_sat #(
        .DW   (DW),
        .FRAC (FRAC),
        .ACCW (ACCW)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clr     (mac_clr),
        .en      (dat_vld_reg),
        .mode    (mac_mode),
        .gate    (mac_gate),
        .din     ($signed(mdata_r)),
        .hin     (mac_hin),
        .act_sel (act_reg),
        .result  (mac_result)
    );

endmodule

// File: tb/tb_rnn_seq_core.sv
module tb_rnn_seq_core;

    localparam int HID = 4, IN_BITS = 4, DW = 20, FRAC = 16, TW = 11, AW = 17;
    localparam longint ONE  = longint'(1) << FRAC;
    localparam longint DMAX = (longint'(1) << (DW - 1)) - 1;
    localparam longint MASK = (longint'(1) << DW) - 1;

    logic          clk = 1'b0;
    logic          reset, ready, act_sel;
    logic [31:0]   idata = '0;
    logic [DW-1:0] mdata_r = '0;
    logic          busy, i_en, mce;
    logic [2:0]    msel;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdata_w;

    rnn_seq_core #(
        .HID(HID), .IN_BITS(IN_BITS), .DW(DW), .FRAC(FRAC), .TW(TW), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready), .act_sel(act_sel),
        .idata(idata), .mdata_r(mdata_r), .busy(busy), .i_en(i_en),
        .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w)
    );

    always #5 clk = ~clk;

    // Memory image and host input stream
    int          wx [HID*IN_BITS];
    int          wh [HID*HID];
    int          b1 [HID];
    int          b1_late [HID];   // bias1 seen for t>=1
    int          b2 [HID];
    int          hdr_t;
    logic [31:0] xs [8];
    bit          run_clr = 1'b0;
    int          in_cnt = 0;
    int          cyc = 0;
    int          got_addr[$];
    int          got_val[$];
    int          got_cyc[$];
    longint      exp_h [8*HID];

    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) begin
        int a;
        a = int'(maddr);
        cyc <= cyc + 1;
        if (run_clr) begin
            in_cnt <= 0;
            got_addr.delete();
            got_val.delete();
            got_cyc.delete();
        end else begin
            if (i_en) begin
                idata  <= xs[in_cnt % 8];
                in_cnt <= in_cnt + 1;
            end
            if (mce && msel == 3'b101) begin
                got_addr.push_back(a);
                got_val.push_back(int'(mdata_w));
                got_cyc.push_back(cyc);
            end
        end
        if (mce) begin
            case (msel)
                3'b000:  mdata_r <= DW'(wx[a % (HID*IN_BITS)]);
                3'b001:  mdata_r <= DW'((in_cnt >= 2) ? b1_late[a % HID] : b1[a % HID]);
                3'b010:  mdata_r <= DW'(wh[a % (HID*HID)]);
                3'b011:  mdata_r <= DW'(b2[a % HID]);
                3'b100:  mdata_r <= DW'(hdr_t);
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rs(input int m);
        return int'($urandom_range(0, 2*m)) - m;
    endfunction

    // Reference: h_t[j] from plain integer arithmetic on real-valued weights
    task automatic model_run(input int T, input bit act);
        longint hp [HID];
        longint hc [HID];
        longint acc, q;
        for (int t = 0; t < T; t++) begin
            for (int j = 0; j < HID; j++) begin
                acc = (longint'((t == 0) ? b1[j] : b1_late[j]) + longint'(b2[j])) * ONE;
                for (int k = 0; k < IN_BITS; k++)
                    if (xs[t][k]) acc += longint'(wx[j*IN_BITS+k]) * ONE;
                if (t > 0)
                    for (int i = 0; i < HID; i++) acc += hp[i] * longint'(wh[j*HID+i]);
                if (acc >= 0) q = (acc + ONE/2) / ONE;
                else          q = -((-acc + ONE/2) / ONE);
                if (!act) q = (q > ONE) ? ONE : ((q < -ONE) ? -ONE : q);
                else      q = (q < 0) ? 0 : ((q > DMAX) ? DMAX : q);
                hc[j] = q;
                exp_h[t*HID+j] = q;
            end
            hp = hc;
        end
    endtask

    task automatic check_model(input int T, input string tag);
        chk({tag, "_nwrites"}, got_val.size(), T*HID);
        for (int n = 0; n < T*HID && n < got_val.size(); n++) begin
            chk($sformatf("%s_addr%0d", tag, n), got_addr[n], n);
            chk($sformatf("%s_h%0d", tag, n), got_val[n], exp_h[n] & MASK);
        end
    endtask

    task automatic do_run(input bit act, output int busy_cyc);
        run_clr = 1'b1;
        tick();
        run_clr = 1'b0;
        ready   = 1'b1;
        act_sel = act;
        tick();
        ready   = 1'b0;
        act_sel = ~act;           // must have been latched at start
        busy_cyc = 0;
        while (busy && busy_cyc < 5000) begin
            busy_cyc++;
            tick();
        end
        chk("run_done", busy, 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < HID*IN_BITS; i++) wx[i] = 0;
        for (int i = 0; i < HID*HID; i++) wh[i] = 0;
        for (int j = 0; j < HID; j++) begin b1[j] = 0; b1_late[j] = 0; b2[j] = 0; end
        for (int t = 0; t < 8; t++) xs[t] = '0;
    endtask

    task automatic fill_random(input int T);
        hdr_t = T;
        for (int i = 0; i < HID*IN_BITS; i++) wx[i] = rs(32'h0FFFF);
        for (int i = 0; i < HID*HID; i++) wh[i] = rs(32'h1FFFF);
        for (int j = 0; j < HID; j++) begin
            b1[j] = rs(32'h0FFFF); b1_late[j] = b1[j]; b2[j] = rs(32'h0FFFF);
        end
        for (int t = 0; t < 8; t++) xs[t] = $urandom;
    endtask

    initial begin
        int bc;
        int w;
        int saved;
        reset = 1'b1; ready = 1'b0; act_sel = 1'b0;
        clear_mem();
        hdr_t = 0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_i_en", i_en, 0);
        chk("rst_mce", mce, 0);
        chk("rst_msel", msel, 3'b100);
        chk("rst_maddr", maddr, 0);
        chk("rst_mdata_w", mdata_w, 0);
        reset = 1'b0;
        tick();

        // Empty header: two busy cycles, nothing else
        do_run(1'b0, bc);
        chk("t0_busy_cycles", bc, 2);
        chk("t0_i_en_count", in_cnt, 0);
        chk("t0_writes", got_val.size(), 0);

        // Hard-tanh clamp of 3.0
        clear_mem();
        hdr_t = 1;
        for (int j = 0; j < HID; j++) begin b1[j] = 'h8000; b1_late[j] = 'h8000; b2[j] = 'h8000; end
        for (int i = 0; i < HID*IN_BITS; i++) wx[i] = 'h10000;
        xs[0] = 32'h5;
        do_run(1'b0, bc);
        chk("clamp_busy_cycles", bc, 2 + 2 + HID*8);
        chk("clamp_i_en_count", in_cnt, 1);
        chk("clamp_nwrites", got_val.size(), HID);
        for (int j = 0; j < HID && j < got_val.size(); j++) begin
            chk($sformatf("clamp_addr%0d", j), got_addr[j], j);
            chk($sformatf("clamp_h%0d", j), got_val[j], 'h10000);
            if (j > 0) chk($sformatf("clamp_lat%0d", j), got_cyc[j] - got_cyc[j-1], 8);
        end

        // Recurrent term: h_0 = 0.25 from bias1, then 4 * 0.25 * 1.0
        clear_mem();
        hdr_t = 2;
        for (int j = 0; j < HID; j++) b1[j] = 'h4000;
        for (int i = 0; i < HID*HID; i++) wh[i] = 'h10000;
        do_run(1'b0, bc);
        chk("rec_busy_cycles", bc, 2 + (2 + HID*8) + (2 + HID*12));
        chk("rec_nwrites", got_val.size(), 2*HID);
        for (int n = 0; n < 2*HID && n < got_val.size(); n++) begin
            chk($sformatf("rec_addr%0d", n), got_addr[n], n);
            chk($sformatf("rec_h%0d", n), got_val[n], (n < HID) ? 'h4000 : 'h10000);
        end
        if (got_cyc.size() >= HID + 2)
            chk("rec_lat_t1", got_cyc[HID+1] - got_cyc[HID], 12);

        // Rounding: 1 LSB times +-0.5 and +-(0.5 - 2^-16)
        clear_mem();
        hdr_t = 2;
        for (int j = 0; j < HID; j++) b1[j] = 1;
        wh[0*HID] = -'h8000;
        wh[1*HID] = 'h8000;
        wh[2*HID] = -'h7FFF;
        wh[3*HID] = 'h7FFF;
        do_run(1'b0, bc);
        chk("rnd_nwrites", got_val.size(), 2*HID);
        if (got_val.size() == 2*HID) begin
            chk("rnd_h0_0", got_val[0], 1);
            chk("rnd_neg_half", got_val[HID+0], 'hFFFFF);
            chk("rnd_pos_half", got_val[HID+1], 1);
            chk("rnd_neg_below", got_val[HID+2], 0);
            chk("rnd_pos_below", got_val[HID+3], 0);
        end

        // ReLU: -3.0 -> 0, +20.0 -> DW max
        clear_mem();
        hdr_t = 1;
        b1[0] = -'h30000;
        for (int j = 1; j < HID; j++) begin
            b1[j] = 'h50000; b2[j] = 'h50000;
            for (int k = 0; k < IN_BITS; k++) wx[j*IN_BITS+k] = 'h28000;
        end
        xs[0] = 32'hF;
        do_run(1'b1, bc);
        chk("relu_nwrites", got_val.size(), HID);
        for (int j = 0; j < HID && j < got_val.size(); j++)
            chk($sformatf("relu_h%0d", j), got_val[j], (j == 0) ? 0 : 'h7FFFF);

        // Randomized runs against the reference model
        for (int r = 0; r < 4; r++) begin
            fill_random(3);
            model_run(3, r[0]);
            do_run(r[0], bc);
            chk($sformatf("rand%0d_busy_cycles", r), bc, 2 + (2 + HID*8) + 2*(2 + HID*12));
            check_model(3, $sformatf("rand%0d", r));
        end

        // Abort mid-READ at t=1, then a clean rerun
        fill_random(2);
        model_run(2, 1'b0);
        run_clr = 1'b1; tick(); run_clr = 1'b0;
        ready = 1'b1; act_sel = 1'b0; tick(); ready = 1'b0;
        w = 0;
        while (got_val.size() < HID && w < 500) begin w++; tick(); end
        chk("abort_t0_done", got_val.size(), HID);
        repeat (4) tick();
        chk("abort_in_read", (mce && msel != 3'b101), 1);
        reset = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_mce", mce, 0);
        chk("abort_msel", msel, 3'b100);
        chk("abort_i_en", i_en, 0);
        reset = 1'b0;
        saved = got_val.size();
        repeat (40) tick();
        chk("abort_no_writes", got_val.size(), saved);
        for (int n = 0; n < HID && n < got_val.size(); n++)
            chk($sformatf("abort_h%0d", n), got_val[n], exp_h[n] & MASK);
        do_run(1'b0, bc);
        check_model(2, "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
